// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the core
// load/store path and the debug/DMA port.
package dmem_arb_pkg;

  localparam int DATA_W = 32;
  localparam int MODE_W = 3;

  // Access Mode encoding, identical to the one MEMControlUnit drives.
  localparam logic [MODE_W-1:0] MODE_BYTE  = 3'b000;
  localparam logic [MODE_W-1:0] MODE_HALF  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_WORD  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_BYTEU = 3'b100;
  localparam logic [MODE_W-1:0] MODE_HALFU = 3'b101;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              re;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MODE_W-1:0] mode;
  } mem_req_t;

  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Debug/DMA port bundle: request channel plus registered read-response channel.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              valid;
  logic              ready;
  logic              we;
  logic              lock;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [MODE_W-1:0] mode;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, we, lock, addr, wdata, mode,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, lock, addr, wdata, mode,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] count_r;

  // Count register: clears on reset or clr, holds once MAX is reached.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != MAX_V)) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign sat   = (count_r == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the core load/store path (priority) and a
// debug/DMA port that is guaranteed service after MAX_WAIT cycles and may lock bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [DATA_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [MODE_W-1:0] core_mode,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  dmem_arbiter_if.slave     dbg,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MODE_W-1:0] mem_mode,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = cnt_width(MAX_WAIT);
  localparam int BEAT_W = cnt_width(MAX_BURST);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);
  localparam logic              LOCK_EN   = (MAX_BURST > 1);

  arb_state_t        st_r;
  logic [WAIT_W-1:0] wait_cnt_s;
  logic              wait_sat_s;
  logic [BEAT_W-1:0] beat_cnt_s;
  logic              beat_sat_s;

  logic core_req_s;
  logic dbg_own_s;
  logic dbg_ready_s;
  logic core_stall_s;
  logic xfer_s;
  logic burst_enter_s;
  logic burst_exit_s;
  logic beat_last_s;
  logic beat_inc_s;
  logic wait_inc_s;
  logic wait_clr_s;

  mem_req_t core_bus_s;
  mem_req_t dbg_bus_s;
  mem_req_t mem_req_s;

  logic              rvalid_r;
  logic [DATA_W-1:0] rdata_r;

  // Ownership: a live burst keeps debug; otherwise the core wins unless debug has waited out MAX_WAIT.
  always_comb begin
    core_req_s = core_re | core_we;
    if (st_r == BURST) begin
      dbg_own_s = 1'b1;
    end else begin
      dbg_own_s = dbg.valid & (~core_req_s | (wait_cnt_s == WAIT_MAX));
    end
    dbg_ready_s  = dbg_own_s & ~reset;
    core_stall_s = core_req_s & dbg_own_s & ~reset;
    xfer_s       = dbg.valid & dbg_ready_s;
  end

  // Memory request mux; a debug-owned cycle without dbg.valid issues no access.
  always_comb begin
    core_bus_s = '{re: core_re, we: core_we, addr: core_addr,
                   wdata: core_wdata, mode: core_mode};
    dbg_bus_s  = '{re: dbg.valid & ~dbg.we, we: dbg.valid & dbg.we,
                   addr: dbg.addr, wdata: dbg.wdata, mode: dbg.mode};
    mem_req_s  = core_bus_s;
    if (reset) begin
      mem_req_s.re = 1'b0;
      mem_req_s.we = 1'b0;
    end else if (dbg_own_s) begin
      mem_req_s = dbg_bus_s;
    end else begin
      mem_req_s = core_bus_s;
    end
  end

  // Burst bookkeeping and wait-counter control.
  always_comb begin
    beat_last_s   = (beat_cnt_s == BEAT_LAST) | beat_sat_s;
    burst_enter_s = 1'b0;
    if (st_r == BURST) begin
      burst_exit_s = ~dbg.valid | ~dbg.lock | beat_last_s;
      beat_inc_s   = xfer_s;
    end else begin
      burst_exit_s  = 1'b0;
      burst_enter_s = xfer_s & dbg.lock & LOCK_EN;
      beat_inc_s    = burst_enter_s;
    end
    wait_inc_s = dbg.valid & ~dbg_ready_s & ~wait_sat_s;
    wait_clr_s = xfer_s | ~dbg.valid | burst_exit_s;
  end

  sat_counter #(
    .MAX (MAX_WAIT),
    .W   (WAIT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wait_inc_s),
    .clr   (wait_clr_s),
    .count (wait_cnt_s),
    .sat   (wait_sat_s)
  );

  sat_counter #(
    .MAX (MAX_BURST),
    .W   (BEAT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (beat_inc_s),
    .clr   (burst_exit_s),
    .count (beat_cnt_s),
    .sat   (beat_sat_s)
  );

  // Arbitration state: enter BURST on a locked transfer, fall back to ARB on any exit condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_r <= ARB;
    end else begin
      case (st_r)
        ARB:     st_r <= burst_enter_s ? BURST : ARB;
        BURST:   st_r <= burst_exit_s ? ARB : BURST;
        default: st_r <= ARB;
      endcase
    end
  end

  // Registered read response, one cycle after the read transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_W{1'b0}};
    end else begin
      rvalid_r <= xfer_s & ~dbg.we;
      rdata_r  <= (xfer_s & ~dbg.we) ? mem_rdata : rdata_r;
    end
  end

  assign dbg.ready  = dbg_ready_s;
  assign dbg.rvalid = rvalid_r;
  assign dbg.rdata  = rdata_r;
  assign core_stall = core_stall_s;
  assign core_rdata = mem_rdata;
  assign mem_re     = mem_req_s.re;
  assign mem_we     = mem_req_s.we;
  assign mem_addr   = mem_req_s.addr;
  assign mem_wdata  = mem_req_s.wdata;
  assign mem_mode   = mem_req_s.mode;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a cycle-level reference model and memory scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MW = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        core_re = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
  logic [2:0]  core_mode = MODE_WORD;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_mode;

  dmem_arbiter_if dbg();
  dmem_arbiter_if dbg0();

  logic [31:0] core_rdata0, mem_addr0, mem_wdata0;
  logic        core_stall0, mem_re0, mem_we0;
  logic [2:0]  mem_mode0;
  logic [31:0] zero_rdata = 32'h0;

  dmem_arbiter #(.MAX_WAIT(MW), .MAX_BURST(MB)) u_dut (
    .clk(clk), .reset(reset),
    .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_mode(core_mode),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg(dbg.slave),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mode(mem_mode), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.MAX_WAIT(0), .MAX_BURST(MB)) u_dut0 (
    .clk(clk), .reset(reset),
    .core_re(core_re), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_mode(core_mode),
    .core_rdata(core_rdata0), .core_stall(core_stall0),
    .dbg(dbg0.slave),
    .mem_re(mem_re0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_mode(mem_mode0), .mem_rdata(zero_rdata)
  );

  // Environment memory: combinational read, write at the clock edge.
  logic [31:0] bmem [0:255];
  assign mem_rdata = bmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) bmem[mem_addr[9:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] widx(input logic [31:0] a);
    return a[9:2];
  endfunction

  // Reference model state
  logic        m_burst = 1'b0;
  int          m_beats = 0;
  int          m_wait = 0;
  logic        m_rpend = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] ref_mem [0:255];
  int          xq_cyc[$];
  logic [31:0] xq_addr[$];

  always @(negedge clk) begin
    logic creq, e_rdy, e_stall, e_re, e_we, xfer;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_mode;
    creq = core_re | core_we;
    if (reset) e_rdy = 1'b0;
    else if (m_burst) e_rdy = 1'b1;
    else e_rdy = dbg.valid && (!creq || m_wait >= MW);
    e_stall = !reset && creq && e_rdy;
    if (reset) begin
      e_re = 1'b0; e_we = 1'b0; e_addr = core_addr; e_wdata = core_wdata; e_mode = core_mode;
    end else if (e_rdy) begin
      e_re = dbg.valid && !dbg.we; e_we = dbg.valid && dbg.we;
      e_addr = dbg.addr; e_wdata = dbg.wdata; e_mode = dbg.mode;
    end else begin
      e_re = core_re; e_we = core_we; e_addr = core_addr; e_wdata = core_wdata; e_mode = core_mode;
    end
    chk("dbg_ready", {31'h0, dbg.ready}, {31'h0, e_rdy});
    chk("core_stall", {31'h0, core_stall}, {31'h0, e_stall});
    chk("mem_re_we", {30'h0, mem_re, mem_we}, {30'h0, e_re, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_mode", {29'h0, mem_mode}, {29'h0, e_mode});
    chk("dbg_rvalid", {31'h0, dbg.rvalid}, {31'h0, m_rpend});
    if (m_rpend) chk("dbg_rdata", dbg.rdata, m_rdata);
    if (!reset && core_re && !e_stall) chk("core_rdata", core_rdata, ref_mem[widx(core_addr)]);

    if (reset) begin
      m_burst = 1'b0; m_beats = 0; m_wait = 0; m_rpend = 1'b0;
    end else begin
      xfer = dbg.valid && e_rdy;
      m_rpend = xfer && !dbg.we;
      if (m_rpend) m_rdata = ref_mem[widx(dbg.addr)];
      if (xfer && dbg.we) ref_mem[widx(dbg.addr)] = dbg.wdata;
      if (!e_rdy && core_we) ref_mem[widx(core_addr)] = core_wdata;
      if (xfer) begin xq_cyc.push_back(cyc); xq_addr.push_back(dbg.addr); end
      if (dbg.valid && !e_rdy) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else m_wait = 0;
      if (m_burst) begin
        if (!dbg.valid) begin
          m_burst = 1'b0; m_beats = 0; m_wait = 0;
        end else begin
          m_beats++;
          if (!dbg.lock || m_beats == MB) begin m_burst = 1'b0; m_beats = 0; m_wait = 0; end
        end
      end else if (xfer && dbg.lock && MB > 1) begin
        m_burst = 1'b1; m_beats = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_dbg();
    dbg.valid = 1'b0; dbg.we = 1'b0; dbg.lock = 1'b0;
  endtask

  // Present one beat until it is accepted, bounded by a cycle budget.
  task automatic dbg_xfer(input logic we, input logic lock, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    logic done = 1'b0;
    dbg.valid = 1'b1; dbg.we = we; dbg.lock = lock; dbg.addr = addr; dbg.wdata = wdata;
    while (!done && n < 20) begin
      @(negedge clk);
      done = dbg.ready;
      step();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL dbg_timeout addr=%h got no handshake expected one within 20 cycles", addr);
    end
  endtask

  initial begin
    int s, base;
    int exp_off[6];
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int s, base;
    int exp_off[6];
    exp_off = '{4, 5, 6, 7, 12, 13};
    for (int i = 0; i < 256; i++) begin bmem[i] = 32'h0; ref_mem[i] = 32'h0; end
    dbg.valid = 1'b1; dbg.we = 1'b1; dbg.lock = 1'b0; dbg.addr = 32'h10;
    dbg.wdata = 32'h1111_1111; dbg.mode = MODE_WORD;
    dbg0.valid = 1'b0; dbg0.we = 1'b0; dbg0.lock = 1'b0; dbg0.addr = 32'h0;
    dbg0.wdata = 32'h0; dbg0.mode = MODE_WORD;

    // 1: reset holds debug off
    repeat (2) begin
      @(negedge clk);
      chk("t1_rst_ready", {31'h0, dbg.ready}, 32'h0);
      chk("t1_rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("t1_rst_rvalid", {31'h0, dbg.rvalid}, 32'h0);
    end
    step(); reset = 1'b0;
    @(negedge clk);
    chk("t1_ready_after_rst", {31'h0, dbg.ready}, 32'h1);
    step(); idle_dbg();

    // 2: core always requesting, debug waits MAX_WAIT cycles
    core_re = 1'b1; core_addr = 32'h80;
    step();
    s = cyc;
    dbg_xfer(1'b1, 1'b0, 32'h100, 32'hA5A5_0100);
    idle_dbg();
    chk("t2_xfer_offset", xq_cyc[$] - s, 32'd4);
    @(negedge clk);
    chk("t2_stall_after", {31'h0, core_stall}, 32'h0);

    // 6: MAX_WAIT=0 instance, debug wins a tie
    step(); dbg0.valid = 1'b1;
    @(negedge clk);
    chk("t6_ready0", {31'h0, dbg0.ready}, 32'h1);
    chk("t6_stall0", {31'h0, core_stall0}, 32'h1);
    step(); dbg0.valid = 1'b0;
    @(negedge clk);
    chk("t6_ready0_idle", {31'h0, dbg0.ready}, 32'h0);
    chk("t6_stall0_idle", {31'h0, core_stall0}, 32'h0);
    step();

    // 3: locked 6-beat write with the core busy
    base = xq_cyc.size();
    s = cyc;
    for (int i = 0; i < 6; i++) dbg_xfer(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'h3000_0000 + 32'(i));
    idle_dbg();
    step();
    chk("t3_beats", xq_cyc.size() - base, 32'd6);
    for (int i = 0; i < 6 && base + i < xq_cyc.size(); i++) begin
      chk("t3_beat_offset", xq_cyc[base + i] - s, exp_off[i]);
      chk("t3_beat_addr", xq_addr[base + i], 32'h200 + 32'(4 * i));
      chk("t3_beat_data", bmem[widx(32'h200 + 32'(4 * i))], 32'h3000_0000 + 32'(i));
    end

    // 4: write then read back through the registered response
    core_re = 1'b0;
    step();
    dbg_xfer(1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF);
    dbg_xfer(1'b0, 1'b0, 32'h40, 32'h0);
    idle_dbg();
    @(negedge clk);
    chk("t4_rvalid", {31'h0, dbg.rvalid}, 32'h1);
    chk("t4_rdata", dbg.rdata, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk("t4_rvalid_drop", {31'h0, dbg.rvalid}, 32'h0);
    step();

    // 5: reset on the second beat of a locked burst
    dbg.valid = 1'b1; dbg.we = 1'b1; dbg.lock = 1'b1; dbg.addr = 32'h300; dbg.wdata = 32'h5555_0300;
    @(negedge clk);
    chk("t5_beat1_ready", {31'h0, dbg.ready}, 32'h1);
    step();
    reset = 1'b1; dbg.addr = 32'h304; dbg.wdata = 32'h5555_0304;
    @(negedge clk);
    chk("t5_rst_ready", {31'h0, dbg.ready}, 32'h0);
    chk("t5_rst_mem_we", {31'h0, mem_we}, 32'h0);
    step();
    reset = 1'b0; core_re = 1'b1; dbg.addr = 32'h308; dbg.lock = 1'b0;
    @(negedge clk);
    chk("t5_tie_ready", {31'h0, dbg.ready}, 32'h0);
    chk("t5_tie_stall", {31'h0, core_stall}, 32'h0);
    step();
    idle_dbg(); core_re = 1'b0;
    step();
    @(negedge clk);
    chk("t5_beat2_not_written", bmem[widx(32'h304)], 32'h0);
    chk("t5_beat1_written", bmem[widx(32'h300)], 32'h5555_0300);
    chk("t4_mem_word", bmem[widx(32'h40)], 32'hDEAD_BEEF);
    begin
      int diff = 0;
      for (int i = 0; i < 256; i++) if (bmem[i] !== ref_mem[i]) diff++;
      chk("mem_scoreboard_diffs", 32'(diff), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
